pll_rst_seq: RTL and testbench
==============================

# pll_rst_seq

Reset sequencer and lock monitor on the far side of the PLL's `reset`/`lock` interface. It runs on the free-running PLL input clock and drives the PLL's active-high `reset`. It then waits for `lock` to be stable and releases a system reset. If lock is lost, or never arrives within a timeout, it re-cycles the PLL. It sits at the top level between the board oscillator, the `rPLL` wrapper and every reset consumer in the design.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_reset` is held high per attempt (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum cycles in WAIT_LOCK before retry (> LOCK_STABLE_CYCLES).
- `LOSS_FILTER_CYCLES`, 4: consecutive synchronized-lock-low cycles in RUN that count as lock loss (≥1).
- `RETRY_W`, 4: width of retry counter.

Ports:
- `clkin`, in, 1: free-running reference clock, the same net that feeds the PLL.
- `resetn`, in, 1: asynchronous, active-low reset.
- `pll_lock`, in, 1: PLL `lock`; asynchronous to `clkin`.
- `pll_reset`, out, 1: to PLL `reset`, active high.
- `sys_rst_n`, out, 1: system reset, active low. Asserts asynchronously with `resetn`. Deasserts synchronously to `clkin`.
- `pll_ok`, out, 1: high exactly while in RUN.
- `retry_cnt`, out, RETRY_W: saturating count of RESET_PLL re-entries since `resetn`.
- `state_o`, out, 2: current state encoding, for debug.

## Operation
- `pll_lock` passes through a 2-FF synchronizer to produce `lock_s`, with 2 cycles of latency. All decisions use `lock_s` only.
- States: RESET_PLL=0, WAIT_LOCK=1, RUN=2. Encoding 3 is unreachable and recovers to RESET_PLL.
- While `resetn` is low: state=RESET_PLL, all counters=0, `pll_reset`=1, `sys_rst_n`=0, `pll_ok`=0, `retry_cnt`=0.
- RESET_PLL:
  - `pll_reset`=1, `sys_rst_n`=0.
  - A cycle counter runs 0..PLL_RST_CYCLES-1. At the terminal count the block moves to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_reset`=0, `sys_rst_n`=0.
  - The stable counter increments while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - Stable counter reaching LOCK_STABLE_CYCLES-1 with `lock_s`=1 → RUN.
  - The timeout counter increments every cycle in this state. Reaching LOCK_TIMEOUT_CYCLES-1 → RESET_PLL and `retry_cnt`++.
  - If the stable and timeout terminal counts occur in the same cycle, RUN wins.
- RUN:
  - `pll_reset`=0, `sys_rst_n`=1, `pll_ok`=1.
  - The loss counter counts consecutive `lock_s`=0 cycles and clears on `lock_s`=1.
  - Reaching LOSS_FILTER_CYCLES → RESET_PLL and `retry_cnt`++.
- `retry_cnt` saturates at 2^RETRY_W-1 and never wraps.
- All counters clear on every state entry.
- Counter widths are `$clog2` of their respective parameter, plus 1 where needed to hold the terminal value.
- `resetn` asserted mid-operation immediately forces the reset values above, regardless of state.

## Timing
- All outputs are registered and change on the `clkin` edge where the state changes. No combinational path runs from `pll_lock` to any output.
- From `resetn` release to the first `pll_reset` fall: PLL_RST_CYCLES cycles.
- From `pll_lock` rising and staying high during WAIT_LOCK to `sys_rst_n` rising: 2 + LOCK_STABLE_CYCLES cycles, ±1 for the sampling phase.
- From `pll_lock` falling in RUN to `sys_rst_n` falling: 2 + LOSS_FILTER_CYCLES cycles.
- A low glitch on `lock_s` shorter than LOSS_FILTER_CYCLES has no effect.
- Downstream clock domains (the PLL `clkout` domain) re-synchronize `sys_rst_n` themselves. This block does not provide that.

## Configuration
- Macro: `PLL_RST_SEQ_TIMEOUT_EN`.
- Defined: WAIT_LOCK timeout and retry work as specified.
- Undefined:
  - The timeout counter is not built and WAIT_LOCK waits indefinitely.
  - `retry_cnt` counts only lock-loss re-entries.
  - The LOCK_TIMEOUT_CYCLES value is ignored.

## Structure
- Shared package `pll_rst_seq_pkg`: state enum `pll_seq_state_t` (RESET_PLL, WAIT_LOCK, RUN), `STATE_W`=2.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with async active-low reset to 0. It is reused by other CDC points.
- The remainder is one FSM with its counters in `pll_rst_seq`.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, LOSS_FILTER_CYCLES=3, RETRY_W=2.
- Reset release with `pll_lock`=1 from cycle 10 → `pll_reset` high for cycles 0–3. `sys_rst_n` rises at cycle 10+2+8 (±1). `pll_ok`=1 and `retry_cnt`=0.
- `pll_lock` held 0 forever → `pll_reset` re-pulses every 4+32 cycles. `retry_cnt` goes 1, 2, 3 and holds at 3. `sys_rst_n` stays 0.
- In RUN, `pll_lock` low for 2 cycles, then high → no state change and `sys_rst_n` stays 1.
- In RUN, `pll_lock` low for 5 cycles → `sys_rst_n` falls 5 cycles after the lock edge. `pll_reset` pulses for 4 cycles. `retry_cnt`++.
- In WAIT_LOCK, `pll_lock` toggles high for 5 cycles, low for 1, then stays high → RUN is entered only 8 cycles after the final rise, because the stable counter restarts.
- Assert `resetn` while in RUN → on the same edge `sys_rst_n`=0, `pll_reset`=1 and `retry_cnt`=0. With the macro undefined, a 100-cycle lock-low run produces no retry.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and its width.
// Encoding 3 is unused and recovers to RESET_PLL.
package pll_rst_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2
  } pll_seq_state_t;

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset to 0.
// Shared by every single-bit or quasi-static CDC crossing in the design.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer and lock monitor: pulses PLL reset, waits for stable lock,
// releases the system reset and re-cycles the PLL on lock loss. Macro PLL_RST_SEQ_TIMEOUT_EN adds the WAIT_LOCK timeout.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOSS_FILTER_CYCLES  = 4,
  parameter int RETRY_W             = 4
) (
  input  logic               clkin,
  input  logic               resetn,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               sys_rst_n,
  output logic               pll_ok,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam int RST_CW  = $clog2(PLL_RST_CYCLES);
  localparam int STB_CW  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int LOSS_CW = $clog2(LOSS_FILTER_CYCLES + 1);

  localparam logic [RST_CW-1:0]  RST_TERM  = RST_CW'(PLL_RST_CYCLES - 1);
  localparam logic [STB_CW-1:0]  STB_TERM  = STB_CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [LOSS_CW-1:0] LOSS_TERM = LOSS_CW'(LOSS_FILTER_CYCLES - 1);

  if (PLL_RST_CYCLES < 2 || LOCK_STABLE_CYCLES < 1 || LOSS_FILTER_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES || RETRY_W < 1) begin : g_param_check
    $error("pll_rst_seq: illegal parameter combination");
  end

  logic lock_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i   (clkin),
    .rst_n_i (resetn),
    .d_i     (pll_lock),
    .q_o     (lock_s)
  );

  pll_seq_state_t     state_q,   state_d;
  logic [RST_CW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [STB_CW-1:0]  stable_q,  stable_d;
  logic [LOSS_CW-1:0] loss_q,    loss_d;
  logic [RETRY_W-1:0] retry_q,   retry_d;
  logic               retry_evt;
  logic               pll_reset_q, sys_rst_n_q, pll_ok_q;

`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam int TO_CW = $clog2(LOCK_TIMEOUT_CYCLES);
  localparam logic [TO_CW-1:0] TO_TERM = TO_CW'(LOCK_TIMEOUT_CYCLES - 1);
  logic [TO_CW-1:0] timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stable_d  = stable_q;
    loss_d    = loss_q;
    retry_d   = retry_q;
    retry_evt = 1'b0;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
`endif

    case (state_q)
      RESET_PLL: begin
        if (rst_cnt_q == RST_TERM) state_d = WAIT_LOCK;
        else                       rst_cnt_d = rst_cnt_q + 1'b1;
      end
      WAIT_LOCK: begin
        stable_d = lock_s ? stable_q + 1'b1 : '0;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        timeout_d = timeout_q + 1'b1;
`endif
        // Stable lock takes priority over a coincident timeout.
        if (lock_s && stable_q == STB_TERM) begin
          state_d = RUN;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        end else if (timeout_q == TO_TERM) begin
          state_d   = RESET_PLL;
          retry_evt = 1'b1;
`endif
        end
      end
      RUN: begin
        if (lock_s) begin
          loss_d = '0;
        end else if (loss_q == LOSS_TERM) begin
          state_d   = RESET_PLL;
          retry_evt = 1'b1;
        end else begin
          loss_d = loss_q + 1'b1;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    if (state_d != state_q) begin
      rst_cnt_d = '0;
      stable_d  = '0;
      loss_d    = '0;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
      timeout_d = '0;
`endif
    end

    if (retry_evt && retry_q != {RETRY_W{1'b1}}) retry_d = retry_q + 1'b1;
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RESET_PLL;
      rst_cnt_q   <= '0;
      stable_q    <= '0;
      loss_q      <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stable_q    <= stable_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == RESET_PLL);
      sys_rst_n_q <= (state_d == RUN);
      pll_ok_q    <= (state_d == RUN);
    end
  end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) timeout_q <= '0;
    else         timeout_q <= timeout_d;
  end
`endif

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign pll_ok    = pll_ok_q;
  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: vector table for the main sequence plus
// hand-written async-reset, timeout/no-timeout and retry-saturation sequences.
module tb_pll_rst_seq;

  logic       clkin;
  logic       resetn;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       pll_ok;
  logic [1:0] retry_cnt;
  logic [1:0] state_o;

  int checks   = 0;
  int failures = 0;

  pll_rst_seq #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOSS_FILTER_CYCLES  (3),
    .RETRY_W             (2)
  ) dut (
    .clkin     (clkin),
    .resetn    (resetn),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .pll_ok    (pll_ok),
    .retry_cnt (retry_cnt),
    .state_o   (state_o)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       lock;
    int         n;
    logic [1:0] st;
    logic       pr;
    logic       srn;
    logic       ok;
    logic [1:0] rc;
  } vec_t;

  vec_t vecs[15];

  task automatic cycles(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic chk(input string tag, input int idx, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] %s actual=%0d required=%0d", tag, idx, field, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [1:0] st,
                         input logic pr, input logic srn, input logic ok, input logic [1:0] rc);
    chk(tag, idx, "state", 32'(state_o), 32'(st));
    chk(tag, idx, "pll_reset", 32'(pll_reset), 32'(pr));
    chk(tag, idx, "sys_rst_n", 32'(sys_rst_n), 32'(srn));
    chk(tag, idx, "pll_ok", 32'(pll_ok), 32'(ok));
    chk(tag, idx, "retry_cnt", 32'(retry_cnt), 32'(rc));
    $display("txn %s[%0d] state=%0d pll_reset=%0b sys_rst_n=%0b pll_ok=%0b retry=%0d",
             tag, idx, state_o, pll_reset, sys_rst_n, pll_ok, retry_cnt);
  endtask

  initial begin
    // Edge numbers below count posedges after the release negedge.
    vecs[0]  = '{1'b0, 3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0}; // e3: still pulsing PLL reset
    vecs[1]  = '{1'b0, 1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0}; // e4: WAIT_LOCK
    vecs[2]  = '{1'b0, 5, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0}; // e9
    vecs[3]  = '{1'b1, 9, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0}; // e18: one short of release
    vecs[4]  = '{1'b1, 1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd0}; // e19: RUN
    vecs[5]  = '{1'b0, 2, 2'd2, 1'b0, 1'b1, 1'b1, 2'd0}; // 2-cycle glitch
    vecs[6]  = '{1'b1, 6, 2'd2, 1'b0, 1'b1, 1'b1, 2'd0}; // glitch filtered
    vecs[7]  = '{1'b0, 4, 2'd2, 1'b0, 1'b1, 1'b1, 2'd0}; // loss: 4 edges, still RUN
    vecs[8]  = '{1'b0, 1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1}; // 5th edge: RESET_PLL
    vecs[9]  = '{1'b0, 3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[10] = '{1'b0, 1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1}; // 4-cycle pulse done
    vecs[11] = '{1'b1, 5, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1}; // high 5
    vecs[12] = '{1'b0, 1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1}; // low 1
    vecs[13] = '{1'b1, 9, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1}; // stable counter restarted
    vecs[14] = '{1'b1, 1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd1}; // RUN 8 after final rise

    resetn   = 1'b0;
    pll_lock = 1'b0;
    cycles(3);
    chk_all("reset", 0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);

    resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      pll_lock = vecs[i].lock;
      cycles(vecs[i].n);
      chk_all("vec", i, vecs[i].st, vecs[i].pr, vecs[i].srn, vecs[i].ok, vecs[i].rc);
    end

    // Asynchronous assertion in RUN takes effect without a clock edge.
    #2;
    resetn = 1'b0;
    #1;
    chk_all("async_rst", 0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    cycles(2);
    chk_all("async_rst", 1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);

    pll_lock = 1'b0;
    resetn   = 1'b1;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    cycles(4);
    chk_all("timeout", 0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    cycles(31);
    chk_all("timeout", 1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    cycles(1);
    chk_all("timeout", 2, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1);
    for (int k = 2; k <= 4; k++) begin
      cycles(4);
      chk_all("timeout_wait", k, 2'd1, 1'b0, 1'b0, 1'b0, 2'(k - 1 > 3 ? 3 : k - 1));
      cycles(32);
      chk_all("timeout_retry", k, 2'd0, 1'b1, 1'b0, 1'b0, 2'(k > 3 ? 3 : k));
    end
`else
    cycles(4);
    chk_all("no_timeout", 0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    cycles(100);
    chk_all("no_timeout", 1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

    // Lock-loss retries saturate at 3 in either build.
    resetn = 1'b0;
    cycles(2);
    resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      int waited;
      pll_lock = 1'b1;
      waited   = 0;
      while (pll_ok !== 1'b1 && waited < 40) begin
        cycles(1);
        waited++;
      end
      chk("sat_reach_run", i, "pll_ok", 32'(pll_ok), 32'd1);
      pll_lock = 1'b0;
      cycles(4);
      chk_all("sat_hold", i, 2'd2, 1'b0, 1'b1, 1'b1, 2'(i - 1 > 3 ? 3 : i - 1));
      cycles(1);
      chk_all("sat_loss", i, 2'd0, 1'b1, 1'b0, 1'b0, 2'(i > 3 ? 3 : i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
